// File: rtl/brcomp_pkg.sv
// Shared definitions for the sequential branch comparator: funct3 encodings,
// FSM state type and the branch-taken decode.
// Ports: none (package).
package brcomp_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Encodings 010/011 are not branches and never report taken.
   function automatic logic br_taken(input logic [2:0] f3, input logic less, input logic equal);
      logic t;
      case (f3)
         F3_BEQ:           t = equal;
         F3_BNE:           t = ~equal;
         F3_BLT, F3_BLTU:  t = less;
         F3_BGE, F3_BGEU:  t = ~less;
         default:          t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/brcomp_seq_if.sv
// Request/result handshake bundle of the sequential branch comparator.
// Ports: valid_i/ready_o/rs1_data_i/rs2_data_i/funct3_i (request side),
//        valid_o/ready_i/br_less_o/br_equal_o/br_taken_o (result side).
interface brcomp_seq_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] rs1_data_i;
   logic [WIDTH-1:0] rs2_data_i;
   logic [2:0]       funct3_i;
   logic             valid_o;
   logic             ready_i;
   logic             br_less_o;
   logic             br_equal_o;
   logic             br_taken_o;

   // Producer/consumer side driving requests and taking results.
   modport master (
      output valid_i, rs1_data_i, rs2_data_i, funct3_i, ready_i,
      input  ready_o, valid_o, br_less_o, br_equal_o, br_taken_o
   );

   // Comparator side.
   modport slave (
      input  valid_i, rs1_data_i, rs2_data_i, funct3_i, ready_i,
      output ready_o, valid_o, br_less_o, br_equal_o, br_taken_o
   );
endinterface

// File: rtl/brcomp_seq_chunk_compare.sv
// Unsigned magnitude compare of one CHUNK-bit slice.
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i (chunks) -> lt_o, eq_o, gt_o.
module chunk_compare #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic             lt_o,
   output logic             eq_o,
   output logic             gt_o
);
   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);
endmodule

// File: rtl/brcomp_seq.sv
// Multi-cycle RISC-V branch comparator, CHUNK bits per cycle MSB first, early exit.
// Latency: 1 + chunks examined (2..NCHUNK+1) counted from the request cycle.
// Backpressure: result held in DONE until ready_i; no request accepted outside IDLE.
// Ports: clk_i, rst_ni (async active-low), flush_i, bus (brcomp_seq_if.slave).
module brcomp_seq
   import brcomp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   brcomp_seq_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_chk_div
      $error("brcomp_seq: WIDTH must be a multiple of CHUNK");
   end
   if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH) begin : g_chk_range
      $error("brcomp_seq: WIDTH >= 2 and 1 <= CHUNK <= WIDTH required");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       f3_q;
   logic [IW-1:0]    idx_q;
   logic             less_q, equal_q, taken_q;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             c_lt, c_eq, c_gt;
   logic             accept, resolved, last_chunk;
   logic [WIDTH-1:0] sign_flip;

   // Inverting the sign bit of both operands turns signed order into unsigned
   // order; doing it at capture keeps the compare loop sign-agnostic.
   assign sign_flip  = {~bus.funct3_i[1], {(WIDTH-1){1'b0}}};

   assign a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
   assign last_chunk = (idx_q == '0);
   assign accept     = (state_q == IDLE) && bus.valid_i && !flush_i;
   assign resolved   = c_lt || c_gt || (c_eq && last_chunk);

   chunk_compare #(.CHUNK(CHUNK)) u_cmp (
      .a_i  (a_chunk),
      .b_i  (b_chunk),
      .lt_o (c_lt),
      .eq_o (c_eq),
      .gt_o (c_gt)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      bus.ready_o = 1'b0;
      bus.valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ready_o = 1'b1;
            if (accept) state_d = CMP;
         end
         CMP: begin
            if (resolved) state_d = DONE;
         end
         DONE: begin
            bus.valid_o = 1'b1;
            if (bus.ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q     <= '0;
         b_q     <= '0;
         f3_q    <= '0;
         idx_q   <= '0;
         less_q  <= 1'b0;
         equal_q <= 1'b0;
         taken_q <= 1'b0;
      end else if (!flush_i) begin
         if (accept) begin
            a_q   <= bus.rs1_data_i ^ sign_flip;
            b_q   <= bus.rs2_data_i ^ sign_flip;
            f3_q  <= bus.funct3_i;
            idx_q <= IDX_TOP;
         end else if (state_q == CMP) begin
            if (c_lt || c_gt) begin
               less_q  <= c_lt;
               equal_q <= 1'b0;
               taken_q <= br_taken(f3_q, c_lt, 1'b0);
            end else if (last_chunk) begin
               less_q  <= 1'b0;
               equal_q <= 1'b1;
               taken_q <= br_taken(f3_q, 1'b0, 1'b1);
            end else begin
               idx_q <= idx_q - 1'b1;
            end
         end
      end
   end

   assign bus.br_less_o  = less_q;
   assign bus.br_equal_o = equal_q;
   assign bus.br_taken_o = taken_q;

endmodule

// File: tb/tb_brcomp_seq.sv
// Directed bench for brcomp_seq (WIDTH=32, CHUNK=8) with hand-computed results.
// Latency is counted in rising edges from the cycle the request is presented,
// the accept edge being edge 1.
module tb_brcomp_seq;
   import brcomp_pkg::*;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   brcomp_seq_if #(.WIDTH(32)) bus ();

   brcomp_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one request; returns just after the accept edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check("ready_before_req", {31'b0, bus.ready_o}, 32'd1);
      bus.valid_i    = 1'b1;
      bus.funct3_i   = f3;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
   endtask

   // Waits (bounded) for valid_o; leaves the bench at the negedge where it is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      forever begin
         @(negedge clk);
         if (bus.valid_o) break;
         if (lat > 20) begin
            check("valid_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic exp_less,
                         input logic exp_eq, input logic exp_taken);
      int lat;
      issue(f3, a, b);
      wait_valid(lat);
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_less"},  {31'b0, bus.br_less_o},  {31'b0, exp_less});
      check({tag, "_equal"}, {31'b0, bus.br_equal_o}, {31'b0, exp_eq});
      check({tag, "_taken"}, {31'b0, bus.br_taken_o}, {31'b0, exp_taken});
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle_after"}, {30'b0, bus.ready_o, bus.valid_o}, 32'b10);
   endtask

   initial begin
      int  lat;
      logic seen;
      rst_n          = 1'b0;
      flush          = 1'b0;
      bus.valid_i    = 1'b0;
      bus.ready_i    = 1'b1;
      bus.funct3_i   = F3_BEQ;
      bus.rs1_data_i = '0;
      bus.rs2_data_i = '0;

      // Reset state
      #12;
      check("rst_ready", {31'b0, bus.ready_o},    32'd1);
      check("rst_valid", {31'b0, bus.valid_o},    32'd0);
      check("rst_less",  {31'b0, bus.br_less_o},  32'd0);
      check("rst_equal", {31'b0, bus.br_equal_o}, 32'd0);
      check("rst_taken", {31'b0, bus.br_taken_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //      tag     funct3   A             B             lat less eq taken
      run_op("beq",  F3_BEQ,  32'h12345678, 32'h12345678, 5, 1'b0, 1'b1, 1'b1);
      run_op("blt",  F3_BLT,  32'hFFFFFFFF, 32'h00000001, 2, 1'b1, 1'b0, 1'b1);
      run_op("bltu", F3_BLTU, 32'hFFFFFFFF, 32'h00000001, 2, 1'b0, 1'b0, 1'b0);
      run_op("bge",  F3_BGE,  32'h80000000, 32'h7FFFFFFF, 2, 1'b1, 1'b0, 1'b0);
      run_op("bgeu", F3_BGEU, 32'h80000000, 32'h7FFFFFFF, 2, 1'b0, 1'b0, 1'b1);
      run_op("bne",  F3_BNE,  32'h00000005, 32'h00000004, 5, 1'b0, 1'b0, 1'b1);

      // Backpressure: 1 <u 2 decided in the last chunk; consumer stalls 3 cycles
      bus.ready_i = 1'b0;
      issue(F3_BLTU, 32'h00000001, 32'h00000002);
      wait_valid(lat);
      check("bp_lat", lat, 5);
      for (int i = 0; i < 3; i++) begin
         bus.valid_i    = 1'b1;
         bus.funct3_i   = F3_BEQ;
         bus.rs1_data_i = 32'h0;
         bus.rs2_data_i = 32'h0;
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_flags",
               {27'b0, bus.valid_o, bus.ready_o, bus.br_less_o, bus.br_equal_o, bus.br_taken_o},
               32'b10101);
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release", {30'b0, bus.ready_o, bus.valid_o}, 32'b10);
      check("bp_hold_taken_after", {31'b0, bus.br_taken_o}, 32'd1);

      // Request coincident with flush in IDLE is dropped
      bus.valid_i = 1'b1;
      flush       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
      flush       = 1'b0;
      check("flush_blocks_accept", {31'b0, bus.ready_o}, 32'd1);

      // Flush in the second CMP cycle of a 4-chunk compare
      issue(F3_BEQ, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {30'b0, bus.ready_o, bus.valid_o}, 32'b10);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.valid_o) seen = 1'b1;
      end
      check("flush_no_valid", {31'b0, seen}, 32'd0);
      check("flush_keeps_result", {29'b0, bus.br_less_o, bus.br_equal_o, bus.br_taken_o}, 32'b101);

      // Asynchronous reset in the middle of a compare
      issue(F3_BEQ, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_flags",
            {27'b0, bus.ready_o, bus.valid_o, bus.br_less_o, bus.br_equal_o, bus.br_taken_o},
            32'b10000);
      @(negedge clk);
      rst_n = 1'b1;

      // Non-branch funct3 still compares but never takes
      run_op("f3_010", 3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 5, 1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
